tick_counter: RTL

TICK_COUNTER -- requirements
Module: tick_counter

---
 rtl/tick_counter.sv | 103 ++++++++++
 1 files changed

// File: rtl/tick_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tick_counter                                                  |
// | Brief    : Prescaled modulo up/down counter with tick and wrap strobes.  |
// |            Optional synchronous load enabled by TICK_COUNTER_LOAD_EN.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tick_counter #(
    parameter int DIV     = 50_000_000,
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
`ifdef TICK_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic             tick,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0] c_pre_max = PRE_W'(DIV - 1);
    localparam logic [WIDTH-1:0] c_q_max   = WIDTH'(MODULUS - 1);

    logic [PRE_W-1:0] r_pre;
    logic [WIDTH-1:0] r_q;
    logic             r_tick;
    logic             r_wrap;

    logic             w_step;
    logic             w_load;
    logic [WIDTH-1:0] w_load_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;

`ifdef TICK_COUNTER_LOAD_EN
    // Out-of-range load values saturate to the top count state.
    assign w_load   = load;
    assign w_load_q = (load_val > c_q_max) ? c_q_max : load_val;
`else
    assign w_load   = 1'b0;
    assign w_load_q = '0;
`endif

    assign w_step = en && (r_pre == c_pre_max);

    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (!dir) begin
            if (r_q == c_q_max) begin
                w_q_next    = '0;
                w_wrap_next = 1'b1;
            end else begin
                w_q_next = r_q + 1'b1;
            end
        end else begin
            if (r_q == '0) begin
                w_q_next    = c_q_max;
                w_wrap_next = 1'b1;
            end else begin
                w_q_next = r_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre  <= '0;
            r_q    <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_load) begin
            r_pre  <= '0;
            r_q    <= w_load_q;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_step) begin
            r_pre  <= '0;
            r_q    <= w_q_next;
            r_tick <= 1'b1;
            r_wrap <= w_wrap_next;
        end else begin
            if (en) begin
                r_pre <= r_pre + 1'b1;
            end
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign tick = r_tick;
    assign q    = r_q;
    assign wrap = r_wrap;

endmodule
`default_nettype wire
